// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared width constants and FSM state type for the serial adder/subtractor
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must reach WIDTH-1 and the package default needs a ready-made size.
    localparam int CNT_W = $clog2(DEFAULT_WIDTH + 1);

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - one-bit full adder used as the serial arithmetic step
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain combinational full adder: parity sum, majority carry.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_add_sub_seq.sv
// rtl/serial_add_sub_seq.sv - bit-serial add/subtract sequencer; optional ovf output under SERIAL_OVF_FLAG_EN
module serial_add_sub_seq
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             SU,
    input  logic             EO,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             Cout
`ifdef SERIAL_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the low WIDTH-1 result bits; the MSB comes straight from the adder on the final step.
    logic [WIDTH-2:0] part_sr;
    logic [WIDTH-1:0] res_q;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic             sum_bit;
    logic             carry_nxt;
    logic             last_bit;
`ifdef SERIAL_OVF_FLAG_EN
    logic             ovf_q;
`endif

    full_adder_bit u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (sum_bit),
        .cout (carry_nxt)
    );

    assign last_bit = (cnt == LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start is only honoured in IDLE; DONE lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath: operand capture on accept, one LSB-first bit per SHIFT edge, result commit on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            part_sr <= '0;
            res_q   <= '0;
            carry   <= 1'b0;
            cout_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr    <= in1;
                        // Subtraction is A + ~B + 1: invert B and seed the carry with SU.
                        b_sr    <= SU ? ~in2 : in2;
                        carry   <= SU;
                        cnt     <= '0;
                        part_sr <= '0;
                    end
                end
                SHIFT: begin
                    part_sr <= {sum_bit, part_sr[WIDTH-2:1]};
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry   <= carry_nxt;
                    cnt     <= cnt + CW'(1);
                    if (last_bit) begin
                        res_q  <= {sum_bit, part_sr};
                        cout_q <= carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_OVF_FLAG_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state == SHIFT && last_bit) begin
            ovf_q <= carry ^ carry_nxt;
        end
    end

    assign ovf = ovf_q;
`endif

    assign result = EO ? res_q : '0;
    assign Cout   = cout_q;

endmodule

// File: tb/tb_serial_add_sub_seq.sv
// tb/tb_serial_add_sub_seq.sv - self-checking bench with behavioural model for serial_add_sub_seq
module tb_serial_add_sub_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         SU;
    logic         EO;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         Cout;
`ifdef SERIAL_OVF_FLAG_EN
    logic         ovf;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_add_sub_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in1    (in1),
        .in2    (in2),
        .SU     (SU),
        .EO     (EO),
        .busy   (busy),
        .done   (done),
        .result (result),
        .Cout   (Cout)
`ifdef SERIAL_OVF_FLAG_EN
        ,
        .ovf    (ovf)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Arithmetic reference from plain integer maths.
    function automatic void model_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic su,
                                     output logic [W-1:0] r, output logic c, output logic v);
        int ua, ub, sa, sb, s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (su) begin
            r = W'(ua - ub);
            c = (ua >= ub);
            s = sa - sb;
        end else begin
            r = W'(ua + ub);
            c = ((ua + ub) >= (1 << W));
            s = sa + sb;
        end
        v = (s > ((1 << (W - 1)) - 1)) || (s < -(1 << (W - 1)));
    endfunction

    // Timing model: an accepted op keeps busy for W+1 cycles, the last being the done cycle.
    int           m_left;
    logic [W-1:0] m_res, p_res;
    logic         m_cout, p_cout, m_ovf, p_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_res  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                model_op(in1, in2, SU, p_res, p_cout, p_ovf);
                m_left = W + 1;
            end
        end else begin
            m_left--;
            if (m_left == 1) begin
                m_res  = p_res;
                m_cout = p_cout;
                m_ovf  = p_ovf;
            end
        end
    end

    // Per-cycle compare against the model.
    always begin
        @(posedge clk);
        #1;
        chk("busy", busy, m_left != 0);
        chk("done", done, m_left == 1);
        chk("result", result, EO ? m_res : '0);
        chk("Cout", Cout, m_cout);
`ifdef SERIAL_OVF_FLAG_EN
        chk("ovf", ovf, m_ovf);
`endif
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    // One directed operation with literal expectations and latency check.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic su, input logic eo,
                      input logic [W-1:0] er, input logic ec, input logic ev);
        int n;
        wait_idle();
        in1 = a; in2 = b; SU = su; EO = eo; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, 9);
        chk("op_result", result, eo ? er : '0);
        chk("op_Cout", Cout, ec);
        chk("model_result", m_res, er);
        chk("model_Cout", m_cout, ec);
`ifdef SERIAL_OVF_FLAG_EN
        chk("op_ovf", ovf, ev);
`else
        if (ev !== ev) chk("ovf_arg", 0, 1);
`endif
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; SU = 1'b0; EO = 1'b1; in1 = '0; in2 = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_Cout", Cout, 0);
        @(negedge clk);
        rst = 1'b0;

        op(8'h3C, 8'h15, 1'b0, 1'b1, 8'h51, 1'b0, 1'b0);
        op(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        op(8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
        op(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);

        // Enable gating: result hidden with EO=0, appears combinationally when EO rises.
        op(8'h3C, 8'h15, 1'b0, 1'b0, 8'h51, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        EO = 1'b1;
        #1;
        chk("eo_rise", result, 8'h51);

        // Busy guard: a start pulse in SHIFT cycle 3 must be ignored.
        wait_idle();
        in1 = 8'h3C; in2 = 8'h15; SU = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        in1 = 8'hAA; in2 = 8'h11; SU = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (done) dones++;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk("guard_dones", dones, 1);
        chk("guard_result", result, 8'h51);

        // Reset mid-operation after a result with Cout=1.
        op(8'h50, 8'h20, 1'b1, 1'b1, 8'h30, 1'b1, 1'b0);
        wait_idle();
        in1 = 8'hC3; in2 = 8'h5A; SU = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_Cout", Cout, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        op(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);

        // Random traffic: first a held-high start, then random start/EO with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in1   = W'($urandom);
            in2   = W'($urandom);
            SU    = 1'($urandom);
            EO    = (i < 800) ? 1'b1 : 1'($urandom);
            start = (i < 800) ? 1'b1 : ($urandom_range(0, 3) != 0);
            rst   = (i >= 800) && ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_add_sub_seq.md
SERIAL_ADD_SUB_SEQ -- requirements
Module: serial_add_sub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin one operation, sampled only in IDLE.
REQ-005 SHALL have port in1  input  WIDTH  operand A, captured on accepted start.
REQ-006 SHALL have port in2  input  WIDTH  operand B, captured on accepted start.
REQ-007 SHALL have port SU  input  1  mode, 0 = add A+B, 1 = subtract A-B, captured on accepted start.
REQ-008 SHALL have port EO  input  1  output enable for result, combinational, never captured.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress (SHIFT or DONE).
REQ-010 SHALL have port done  output  1  one-cycle pulse, high in the DONE state.
REQ-011 SHALL have port result  output  WIDTH  last completed sum or difference, gated by EO.
REQ-012 SHALL have port Cout  output  1  final carry of the last completed operation.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 SHALL accept start only when in IDLE at a rising edge:
  - latch in1 into the A shift register
  - latch in2, or ~in2 when SU=1, into the B shift register
  - load the carry flop with SU
  - clear the bit counter
  - go to SHIFT
REQ-015 SHALL ignore start while in SHIFT or DONE, with no effect on state, operands or outputs.
REQ-016 In SHIFT, each rising edge SHALL:
  - compute one LSB-first full-adder step: sum = a0^b0^c, carry = majority(a0,b0,c)
  - shift sum into the MSB of the partial-result register
  - shift A and B right
  - increment the counter
REQ-017 SHALL leave SHIFT after exactly WIDTH edges (bits 0..WIDTH-1) and enter DONE. On that edge, the result register SHALL take the completed partial result and Cout SHALL take the final carry.
REQ-018 SHALL assert done for exactly one cycle in DONE, then return to IDLE on the next edge. Latency from the start-accept edge to done high is WIDTH+1 edges (9 for WIDTH=8).
REQ-019 result and Cout SHALL hold their values until the next operation completes; intermediate shifting SHALL never be visible on them.
REQ-020 The result port SHALL equal the result register when EO=1 and all zeros when EO=0. Cout is not gated by EO.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH. In subtract mode, Cout=1 SHALL mean no borrow (A>=B unsigned).
REQ-022 start held high continuously SHALL launch back-to-back operations, one accept per IDLE visit.

Reset
REQ-023 rst high SHALL immediately, independent of clk, force:
  - state to IDLE
  - all shift, counter and carry registers to 0
  - busy=0, done=0, result register 0, Cout=0 (and ovf=0 when present)
REQ-024 Reset during SHIFT or DONE SHALL abort the operation; no done pulse and no result update SHALL follow.

Configuration
REQ-025 With SERIAL_OVF_FLAG_EN defined, the block SHALL add output ovf (1 bit): the two's-complement overflow of the last completed operation, equal to carry-into-MSB XOR carry-out-of-MSB. It SHALL be registered with Cout and SHALL hold with it.
REQ-026 Without SERIAL_OVF_FLAG_EN, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 A shared package serial_arith_pkg SHALL hold:
  - the default width constant (8)
  - the FSM state typedef (IDLE, SHIFT, DONE)
  - the counter width constant, $clog2(WIDTH+1)
REQ-028 The one-bit step SHALL be a sub-module full_adder_bit (a, b, cin -> sum, cout), instantiated once.

Verification
REQ-029 Add: in1=0x3C, in2=0x15, SU=0, EO=1 -> done on edge 9 after accept, result=0x51, Cout=0.
REQ-030 Add wrap: in1=0xFF, in2=0x01, SU=0 -> result=0x00, Cout=1; with the macro, in1=0x7F, in2=0x01 -> result=0x80, ovf=1.
REQ-031 Subtract: 0x50-0x20 -> result=0x30, Cout=1; 0x10-0x20 -> result=0xF0, Cout=0.
REQ-032 Enable gating: complete 0x3C+0x15 with EO=0 -> result=0x00. Raise EO to 1 with no new start -> result=0x51 in the same cycle.
REQ-033 Busy guard: pulse start with new operands in cycle 3 of SHIFT -> ignored; the first operation's result is unchanged and only one done pulse occurs.
REQ-034 Reset mid-operation: assert rst in SHIFT cycle 4 -> busy, done, result and Cout are 0 immediately. A following start with 0x01+0x01 -> result=0x02.
